// File: rtl/chunked_add_pkg.sv
// Shared types and defaults for the chunked wide adder.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the sequencer state encoding and the default chunk width.
package chunked_add_pkg;

    localparam int DEFAULT_CHUNK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_ripple_add.sv
// CHUNK_W-bit combinational ripple-carry adder, time-shared by the sequencer.
// Latency: 0 cycles (purely combinational). Backpressure: none.
// Carry ripples LSB to MSB; cout is the carry out of the top bit.
module chunk_ripple_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[W];

endmodule

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle TOTAL_W adder: one CHUNK_W ripple adder reused over NCHUNK cycles.
// Latency: out_valid rises NCHUNK cycles after the accepting edge; issue interval NCHUNK+2.
// Backpressure: out_ready=0 holds DONE with the result frozen; in_ready=0 outside IDLE.
// Optional subtract mode (in_sub port) when CHUNKED_ADD_SUB_EN is defined.
module chunked_add_sequencer
    import chunked_add_pkg::*;
#(
    parameter int TOTAL_W = 16,
    parameter int CHUNK_W = DEFAULT_CHUNK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] in_a,
    input  logic [TOTAL_W-1:0] in_b,
    input  logic               in_cin,
`ifdef CHUNKED_ADD_SUB_EN
    input  logic               in_sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_sum,
    output logic               out_cout,
    output logic               busy
);

    localparam int NCHUNK = TOTAL_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if ((CHUNK_W < 1) || (TOTAL_W % CHUNK_W != 0)) begin : g_bad_width
            $error("chunked_add_sequencer: TOTAL_W must be a non-zero multiple of CHUNK_W");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [TOTAL_W-1:0] a_q, a_d;
    logic [TOTAL_W-1:0] b_q, b_d;
    logic [TOTAL_W-1:0] sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [TOTAL_W-1:0] b_load;
    logic               cin_load;
    logic [CHUNK_W-1:0] chunk_a;
    logic [CHUNK_W-1:0] chunk_b;
    logic [CHUNK_W-1:0] chunk_sum;
    logic               chunk_cout;

    // Subtraction is A + ~B + 1: invert B once at capture so RUN is identical for both modes.
`ifdef CHUNKED_ADD_SUB_EN
    assign b_load   = in_sub ? ~in_b : in_b;
    assign cin_load = in_sub ? 1'b1  : in_cin;
`else
    assign b_load   = in_b;
    assign cin_load = in_cin;
`endif

    assign chunk_a = a_q[idx_q*CHUNK_W +: CHUNK_W];
    assign chunk_b = b_q[idx_q*CHUNK_W +: CHUNK_W];

    chunk_ripple_add #(
        .W(CHUNK_W)
    ) u_chunk_add (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = b_load;
                    carry_d = cin_load;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK_W +: CHUNK_W] = chunk_sum;
                carry_d = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Scoreboard bench for chunked_add_sequencer (TOTAL_W=16, CHUNK_W=4).
// Exercises subtract mode too when CHUNKED_ADD_SUB_EN is defined.
module tb_chunked_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
`ifdef CHUNKED_ADD_SUB_EN
    logic        in_sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chunked_add_sequencer #(
        .TOTAL_W(16),
        .CHUNK_W(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CHUNKED_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Result side: every handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("out_sum", {16'd0, out_sum}, {16'd0, e[15:0]});
                check("out_cout", {31'd0, out_cout}, {31'd0, e[16]});
            end
        end
    end

    // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output int t);
        logic [16:0] e;
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
`ifdef CHUNKED_ADD_SUB_EN
        in_sub   = sub;
`endif
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("issue_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            t = -1;
            return;
        end
        @(posedge clk); #1;
        t = cyc;
        in_valid = 1'b0;
        if (sub) e = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else     e = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    endtask

    initial begin
        int t0, t1, t2, n;
        logic saw_busy;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
`ifdef CHUNKED_ADD_SUB_EN
        in_sub    = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {16'd0, out_sum}, 32'd0);
        check("rst_cout", {31'd0, out_cout}, 32'd0);
        rst = 1'b0;

        // Full carry ripple across all chunks, with exact latency.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, t0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check("latency_out_valid", {31'd0, out_valid}, {31'd0, (i == 4)});
            if (i < 4) check("run_in_ready", {31'd0, in_ready}, 32'd0);
        end
        drain();

        issue(16'h1234, 16'h4321, 1'b1, 1'b0, t0);
        drain();

        // Backpressure: result frozen, new operands refused.
        out_ready = 1'b0;
        issue(16'hABCD, 16'h9876, 1'b0, 1'b0, t0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_reach_done", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {16'd0, out_sum}, 32'h4443);
            check("bp_cout", {31'd0, out_cout}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (k == 3) begin
                in_valid = 1'b1;
                in_a     = 16'h1111;
                in_b     = 16'h1111;
            end
            if (k == 4) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        saw_busy = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            saw_busy = saw_busy | busy | out_valid;
        end
        check("bp_pulse_not_captured", {31'd0, saw_busy}, 32'd0);

        // Reset two cycles into RUN aborts without a result.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, t0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {16'd0, out_sum}, 32'd0);
        rst = 1'b0;
        issue(16'h00F0, 16'h0F10, 1'b0, 1'b0, t0);
        drain();

        // Back-to-back issue at the minimum interval.
        issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, t1);
        issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, t2);
        check("b2b_interval", t2 - t1, 32'd6);
        drain();

`ifdef CHUNKED_ADD_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, t0);
        drain();
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, t0);
        drain();
`endif

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
